// File: rtl/me_pkg.sv
// -----------------------------------------------------------------------------
// me_pkg
// Shared definitions for the motion-estimation SAD minimum tracker:
//   - default lane widths for SAD and MV components
//   - search state enumeration
//   - SAD_MAX, the all-ones SAD for the default width (the value a lane holds
//     when nothing has been compared yet)
// No ports (package).
// -----------------------------------------------------------------------------
package me_pkg;

  localparam int SAD_W_DEF = 16;
  localparam int MV_W_DEF  = 7;

  localparam logic [SAD_W_DEF-1:0] SAD_MAX = {SAD_W_DEF{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage : me_pkg

// File: rtl/sad_min_tracker_if.sv
// -----------------------------------------------------------------------------
// sad_min_tracker_if
// Bundles the candidate stream (from the SAD adder tree) and the result bus
// (to mode decision) of sad_min_tracker.
//   master : drives start / in_valid / last / sad_in / mv_in, observes results
//   slave  : the tracker itself
// Signals:
//   start     one-cycle pulse, clears trackers and opens a search
//   in_valid  candidate present;  in_ready  candidate taken (SEARCH only)
//   last      final candidate of the window (qualified by in_valid)
//   sad_in    NUM_CH lanes of SAD_W;  mv_in  {y,x}, MV_W each, shared
//   min_sad   per-lane minimum;  min_mv  per-lane {y,x} of that minimum
//   cand_cnt  accepted candidates (saturating);  busy  in SEARCH
//   done      one-cycle pulse, results final
// -----------------------------------------------------------------------------
interface sad_min_tracker_if #(
  parameter int NUM_CH = 4,
  parameter int SAD_W  = 16,
  parameter int MV_W   = 7,
  parameter int CNT_W  = 12
);

  logic                       start;
  logic                       in_valid;
  logic                       in_ready;
  logic                       last;
  logic [NUM_CH*SAD_W-1:0]    sad_in;
  logic [2*MV_W-1:0]          mv_in;
  logic [NUM_CH*SAD_W-1:0]    min_sad;
  logic [NUM_CH*2*MV_W-1:0]   min_mv;
  logic [CNT_W-1:0]           cand_cnt;
  logic                       busy;
  logic                       done;

  modport master (
    output start, in_valid, last, sad_in, mv_in,
    input  in_ready, min_sad, min_mv, cand_cnt, busy, done
  );

  modport slave (
    input  start, in_valid, last, sad_in, mv_in,
    output in_ready, min_sad, min_mv, cand_cnt, busy, done
  );

endinterface : sad_min_tracker_if

// File: rtl/sad_min_cell.sv
// -----------------------------------------------------------------------------
// sad_min_cell
// One partition lane: holds the running minimum SAD and the MV that produced
// it. Loads on the first accepted candidate of a search, or when a candidate
// is strictly smaller (ties keep the earlier MV). i_clear reinitialises to
// all-ones / zero MV.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   i_clear      start of a new search (wins over i_accept)
//   i_accept     candidate taken this cycle
//   i_first      candidate is the first of the search -> unconditional load
//   i_sad, i_mv  candidate SAD lane and {y,x} MV
//   o_min_sad, o_min_mv  registered minimum and its MV
// -----------------------------------------------------------------------------
module sad_min_cell
  import me_pkg::*;
#(
  parameter int SAD_W = SAD_W_DEF,
  parameter int MV_W  = MV_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  input  logic                i_accept,
  input  logic                i_first,
  input  logic [SAD_W-1:0]    i_sad,
  input  logic [2*MV_W-1:0]   i_mv,
  output logic [SAD_W-1:0]    o_min_sad,
  output logic [2*MV_W-1:0]   o_min_mv
);

  localparam logic [SAD_W-1:0]  LANE_MAX = {SAD_W{1'b1}};
  localparam logic [2*MV_W-1:0] MV_ZERO  = {(2*MV_W){1'b0}};

  logic [SAD_W-1:0]  r_min_sad;
  logic [2*MV_W-1:0] r_min_mv;
  logic              w_load;

  // Load decision: first candidate always loads so an all-ones SAD still
  // records its MV; afterwards only a strictly smaller SAD replaces the minimum.
  always_comb begin
    w_load = 1'b0;
    if (i_accept && (i_first || (i_sad < r_min_sad))) begin
      w_load = 1'b1;
    end else begin
      w_load = 1'b0;
    end
  end

  // Minimum / MV registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min_sad <= LANE_MAX;
      r_min_mv  <= MV_ZERO;
    end else if (i_clear) begin
      r_min_sad <= LANE_MAX;
      r_min_mv  <= MV_ZERO;
    end else if (w_load) begin
      r_min_sad <= i_sad;
      r_min_mv  <= i_mv;
    end
  end

  assign o_min_sad = r_min_sad;
  assign o_min_mv  = r_min_mv;

endmodule : sad_min_cell

// File: rtl/sad_min_tracker.sv
// -----------------------------------------------------------------------------
// sad_min_tracker
// Tracks the running minimum SAD of NUM_CH partitions over one search window,
// with the MV of each minimum. A search opens on start, accepts candidates
// while busy, and closes on the accepted candidate flagged last, followed by
// a one-cycle done pulse. start at any time clears and (re)opens a search;
// a candidate presented together with start is discarded.
// Ports:
//   clk    system clock (rising edge)
//   rst_n  asynchronous active-low reset
//   bus    sad_min_tracker_if.slave (candidate stream in, results out)
// -----------------------------------------------------------------------------
module sad_min_tracker
  import me_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SAD_W  = SAD_W_DEF,
  parameter int MV_W   = MV_W_DEF,
  parameter int CNT_W  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  sad_min_tracker_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_first;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  logic             w_clear;
  logic             w_accept;
  logic             w_cnt_inc;

  // start clears in every state; it also suppresses any candidate offered in
  // the same cycle, so accept is gated by it even though in_ready stays high.
  assign w_clear   = bus.start;
  assign w_accept  = bus.in_valid && r_busy && !bus.start;
  assign w_cnt_inc = w_accept && (r_cnt != CNT_MAX);

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_SEARCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (bus.start) begin
          w_state_nxt = ST_SEARCH;
        end else if (w_accept && bus.last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SEARCH;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          w_state_nxt = ST_SEARCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus registered busy/done decoded from the next state, so
  // both outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_SEARCH);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // First-candidate flag: armed by a clear, dropped by the first accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first <= 1'b0;
    end else if (w_clear) begin
      r_first <= 1'b1;
    end else if (w_accept) begin
      r_first <= 1'b0;
    end
  end

  // Accepted-candidate counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_clear) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    sad_min_cell #(
      .SAD_W (SAD_W),
      .MV_W  (MV_W)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (w_clear),
      .i_accept  (w_accept),
      .i_first   (r_first),
      .i_sad     (bus.sad_in[c*SAD_W +: SAD_W]),
      .i_mv      (bus.mv_in),
      .o_min_sad (bus.min_sad[c*SAD_W +: SAD_W]),
      .o_min_mv  (bus.min_mv[c*2*MV_W +: 2*MV_W])
    );
  end

  assign bus.in_ready = r_busy;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.cand_cnt = r_cnt;

endmodule : sad_min_tracker

// File: doc/sad_min_tracker.md
Name: sad_min_tracker

Overview:
- Parametrised successor to the fixed-geometry SAD minimum comparator.
- Tracks the running minimum SAD over one search window for NUM_CH partitions in parallel, together with the motion vector that produced each minimum.
- Adds a start/last framed search with an explicit first-candidate load, an accept handshake, a candidate counter and a done pulse.
- Sits between the SAD adder tree and the mode-decision stage of the ME datapath.

Parameters:
- NUM_CH, 4: number of independent partitions tracked (min 1).
- SAD_W, 16: width of each unsigned SAD lane.
- MV_W, 7: width of each signed MV component (x and y).
- CNT_W, 12: width of the accepted-candidate counter.

Ports:
- clk  in  1  system clock, all flops on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; clears the trackers and opens a new search.
- in_valid  in  1  candidate present on sad_in/mv_in.
- in_ready  out  1  candidate accepted this cycle; high only in SEARCH.
- last  in  1  qualifies in_valid; marks the final candidate of the window.
- sad_in  in  NUM_CH*SAD_W  SAD lanes; lane c occupies bits [c*SAD_W +: SAD_W].
- mv_in  in  2*MV_W  candidate MV, {y,x}; shared by all lanes.
- min_sad  out  NUM_CH*SAD_W  running/final minimum per lane.
- min_mv  out  NUM_CH*2*MV_W  MV of each minimum; lane c occupies bits [c*2*MV_W +: 2*MV_W].
- cand_cnt  out  CNT_W  number of candidates accepted in the current search.
- busy  out  1  high in SEARCH.
- done  out  1  one-cycle pulse; results are final.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE.
  - min_sad all lanes all-ones.
  - min_mv all zero.
  - cand_cnt=0; in_ready=0; busy=0; done=0.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - in_valid is ignored.
  - start -> SEARCH. On the same edge: min_sad <= all-ones, min_mv <= 0, cand_cnt <= 0, first flag set.
- SEARCH:
  - in_ready=1; accept = in_valid && in_ready.
  - Per lane on accept, unsigned compare:
    - if first flag is set, or sad_in lane < min_sad lane (strictly less), load sad_in lane and mv_in.
    - otherwise hold.
  - Ties keep the earlier candidate.
  - The first accept clears the first flag. This guarantees a load even when the SAD equals all-ones.
  - cand_cnt increments on each accept and saturates at all-ones (no wrap).
  - accept && last -> DONE, with the final update applied on that same edge.
  - last without in_valid is ignored.
- DONE:
  - done=1 for exactly this one cycle.
  - Next state is IDLE, unless start is high, in which case go straight to SEARCH with a clear.
  - min_sad, min_mv and cand_cnt hold their values from entering DONE until the next start.
- Latency:
  - A candidate accepted at edge N is visible on min_sad/min_mv after edge N.
  - done is high in the cycle after the last accept.
- start during SEARCH: aborts the search. Trackers are cleared and cand_cnt=0; no done pulse; stay in SEARCH.
- start together with in_valid in SEARCH: start wins and the candidate is discarded (not counted, not compared). in_ready is still 1 that cycle, but the accept is suppressed.
- rst_n low at any time: immediate return to the reset values; any in-flight search is lost.
- Outputs are registered; no combinational path from sad_in to min_sad.

Decomposition:
- Shared package me_pkg holds:
  - SAD_W/MV_W defaults;
  - the state enumeration (IDLE, SEARCH, DONE);
  - constant SAD_MAX = all-ones of SAD_W.
- One sub-module, sad_min_cell, replicated NUM_CH times via generate. It holds the per-lane SAD/MV registers, the compare, and the load on clear/first/less-than.
- The top level holds the FSM, first flag, counter and handshake.

Test Plan:
- Reset with NUM_CH=4, SAD_W=16 -> min_sad=all lanes 0xFFFF, min_mv=0, done=0, busy=0.
- start, then 3 candidates with lane0 SAD=500/300/300 at mv {1,2}/{3,4}/{5,6}, last on the third -> lane0 min=300, mv={3,4} (tie keeps the earlier candidate); cand_cnt=3; done high one cycle after the third accept.
- start, then a single candidate with all lanes 0xFFFF, mv={-1,-1}, last -> each lane min=0xFFFF, mv={-1,-1} (first-candidate load); done pulses.
- Mid-search (2 accepted) assert start together with in_valid carrying SAD=5 -> candidate dropped; cand_cnt=0; min_sad all-ones; no done pulse.
- start in the DONE cycle -> busy the next cycle, trackers cleared, previous results overwritten.
- CNT_W=2 with 5 candidates -> cand_cnt saturates at 3; minimum still correct. Then drop rst_n asynchronously mid-search -> all outputs reach reset values without a clock edge.
